diff_apply: RTL and testbench
=============================

DIFF_APPLY -- requirements
Module: diff_apply

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter IDXW, default 5, bit-index width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 base_in  input  WIDTH  reference word to be patched.
REQ-006 base_equal  input  1  qualifies base_in: 1 = no differences follow, 0 = index stream follows.
REQ-007 base_valid / base_ready  input / output  1 each  base handshake; transfer when both high on a clock edge.
REQ-008 idx_in  input  IDXW  index of one differing bit, LSB = 0.
REQ-009 idx_last  input  1  marks final index of the current difference list.
REQ-010 idx_valid / idx_ready  input / output  1 each  index handshake.
REQ-011 out_word  output  WIDTH  reconstructed word.
REQ-012 out_equal  output  1  1 when no bits were flipped.
REQ-013 out_nflips  output  IDXW+1  number of accepted indices, saturating at WIDTH.
REQ-014 out_err  output  1  duplicate, non-ascending, or out-of-range index seen in this list.
REQ-015 out_valid / out_ready  output / input  1 each  result handshake.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, DONE; exactly one active.
REQ-017 IDLE: base_ready=1, idx_ready=0, out_valid=0.
REQ-018 Base handshake with base_equal=0: load work register with base_in, clear count/err/last-index tracker, next state COLLECT.
REQ-019 Base handshake with base_equal=1: load base_in, count=0, err=0, next state DONE with out_equal=1.
REQ-020 COLLECT: idx_ready=1, base_ready=0; each idx handshake XORs bit idx_in of work register, one index per cycle, no bubbles.
REQ-021 idx handshake with idx_last=1: apply that flip, next state DONE; out_valid high the following cycle (1-cycle latency).
REQ-022 Indices SHALL arrive strictly ascending; idx_in <= previous accepted index in same list sets err (flip still applied, XOR semantics).
REQ-023 idx_in >= WIDTH sets err and SHALL NOT modify the work register.
REQ-024 Count increments per accepted index, saturates at WIDTH; err is sticky until next base handshake.
REQ-025 out_equal SHALL be 1 iff count=0 at entry to DONE.
REQ-026 DONE: out_valid=1, out_word/out_equal/out_nflips/out_err stable until out_ready handshake; base_ready=0, idx_ready=0.
REQ-027 out handshake: next state IDLE; base_ready high the cycle after; no base accepted in the DONE cycle.
REQ-028 idx_valid in IDLE or DONE SHALL be ignored (not consumed); base_valid outside IDLE ignored.
REQ-029 out_word SHALL reflect the work register at all times; only out_valid qualifies it.

Reset
REQ-030 rst high SHALL force IDLE immediately, independent of clk.
REQ-031 Reset values: out_word=0, out_equal=0, out_nflips=0, out_err=0, out_valid=0, idx_ready=0, base_ready=0 while rst high, base_ready=1 from first edge after deassertion.
REQ-032 rst mid-COLLECT or mid-DONE SHALL discard the partial list; no output handshake occurs for it.

Verification
REQ-033 base_in=0x0000_0000, base_equal=0, idx 3,7,31(last) -> out_word=0x8000_0088, out_nflips=3, out_equal=0, out_err=0.
REQ-034 base_in=0xDEAD_BEEF, base_equal=1 -> out_valid 1 cycle after base handshake, out_word=0xDEAD_BEEF, out_equal=1, out_nflips=0.
REQ-035 base_in=0xFFFF_FFFF, idx 4,4(last) -> out_word=0xFFFF_FFFF, out_nflips=2, out_err=1.
REQ-036 out_ready held 0 for 5 cycles in DONE, idx_valid toggling -> outputs stable, no index consumed; on out_ready=1, IDLE next cycle.
REQ-037 rst asserted after 2 of 4 indices -> outputs reset values same cycle; new list 0x1, idx 0(last) -> out_word=0x0, out_nflips=1.
REQ-038 Back-to-back lists with continuous valids -> one index accepted per COLLECT cycle, out_valid exactly 1 cycle after each last index.

Source files
------------

// File: rtl/diff_apply.sv
// Rebuilds a data word from a base word plus an ascending list of bit positions to flip.
// Each list produces one result, with flip count and error flag, through a valid/ready handshake.
module diff_apply #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  base_in,
    input  logic              base_equal,
    input  logic              base_valid,
    output logic              base_ready,
    input  logic [IDXW-1:0]   idx_in,
    input  logic              idx_last,
    input  logic              idx_valid,
    output logic              idx_ready,
    output logic [WIDTH-1:0]  out_word,
    output logic              out_equal,
    output logic [IDXW:0]     out_nflips,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [IDXW:0] WIDTH_W = (IDXW+1)'(WIDTH);

    state_t            state_q, state_d;
    logic              armed_q;
    logic [WIDTH-1:0]  work_q;
    logic [IDXW:0]     count_q;
    logic              err_q;
    logic              equal_q;
    logic              have_prev_q;
    logic [IDXW-1:0]   prev_q;

    logic base_fire, idx_fire, out_fire, idx_oor, idx_order_bad;

    // The armed flag holds base_ready low until the first edge after reset.
    assign base_ready = (state_q == IDLE) && armed_q;
    assign idx_ready  = (state_q == COLLECT);
    assign out_valid  = (state_q == DONE);

    assign base_fire     = base_valid && base_ready;
    assign idx_fire      = idx_valid && idx_ready;
    assign out_fire      = out_valid && out_ready;
    assign idx_oor       = {1'b0, idx_in} >= WIDTH_W;
    assign idx_order_bad = have_prev_q && (idx_in <= prev_q);

    assign out_word   = work_q;
    assign out_equal  = equal_q;
    assign out_nflips = count_q;
    assign out_err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (base_fire) state_d = base_equal ? DONE : COLLECT;
            COLLECT: if (idx_fire && idx_last) state_d = DONE;
            DONE:    if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            equal_q     <= 1'b0;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
        end else if (base_fire) begin
            work_q      <= base_in;
            count_q     <= '0;
            err_q       <= 1'b0;
            equal_q     <= base_equal;
            have_prev_q <= 1'b0;
            prev_q      <= '0;
        end else if (idx_fire) begin
            if (!idx_oor) work_q[idx_in] <= ~work_q[idx_in];
            if (count_q != WIDTH_W) count_q <= count_q + 1'b1;
            if (idx_oor || idx_order_bad) err_q <= 1'b1;
            have_prev_q <= 1'b1;
            prev_q      <= idx_in;
        end
    end

endmodule

// File: tb/tb_diff_apply.sv
// Randomized self-checking bench for diff_apply: list-level reference model plus cycle monitor.
module tb_diff_apply;

    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    logic              clk, rst;
    logic [WIDTH-1:0]  base_in;
    logic              base_equal, base_valid, base_ready;
    logic [IDXW-1:0]   idx_in;
    logic              idx_last, idx_valid, idx_ready;
    logic [WIDTH-1:0]  out_word;
    logic              out_equal;
    logic [IDXW:0]     out_nflips;
    logic              out_err, out_valid, out_ready;

    diff_apply #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .base_in(base_in), .base_equal(base_equal), .base_valid(base_valid), .base_ready(base_ready),
        .idx_in(idx_in), .idx_last(idx_last), .idx_valid(idx_valid), .idx_ready(idx_ready),
        .out_word(out_word), .out_equal(out_equal), .out_nflips(out_nflips), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             equal;
        logic [IDXW:0]    nflips;
        logic             err;
    } res_t;

    res_t exp_q[$];

    // Whole-list reference: flip each listed bit, count, flag ordering/range violations.
    function automatic res_t model(input logic [WIDTH-1:0] base, input logic eq, input int idx[$]);
        res_t r;
        r.word = base; r.equal = 1'b1; r.nflips = '0; r.err = 1'b0;
        if (!eq) begin
            for (int i = 0; i < idx.size(); i++) begin
                if (idx[i] >= WIDTH) r.err = 1'b1;
                else r.word[idx[i]] = ~r.word[idx[i]];
                if (i > 0) begin
                    if (idx[i] <= idx[i-1]) r.err = 1'b1;
                end
            end
            r.nflips = (IDXW+1)'((idx.size() > WIDTH) ? WIDTH : idx.size());
            r.equal  = (idx.size() == 0);
        end
        return r;
    endfunction

    int rdy_mode;  // 0: hold low, 1: random, 2: hold high
    always begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    // Cycle monitor: transaction-level view of what each ready/valid must be.
    bit in_list, exp_vld, armed;
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out_word", out_word, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_idx_ready", idx_ready, 0);
            check("rst_base_ready", base_ready, 0);
            check("rst_flags", {out_equal, out_nflips, out_err}, 0);
            in_list = 0; exp_vld = 0; armed = 0;
            exp_q.delete();
        end else begin
            check("base_ready", base_ready, armed && !in_list && !exp_vld);
            check("idx_ready", idx_ready, in_list);
            check("out_valid", out_valid, exp_vld);
            if (out_valid && exp_vld) begin
                if (exp_q.size() == 0) check("exp_empty", 1, 0);
                else begin
                    check("out_word", out_word, exp_q[0].word);
                    check("out_equal", out_equal, exp_q[0].equal);
                    check("out_nflips", out_nflips, exp_q[0].nflips);
                    check("out_err", out_err, exp_q[0].err);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (base_valid && base_ready) begin
                if (base_equal) exp_vld = 1; else in_list = 1;
            end
            if (idx_valid && idx_ready && idx_last) begin
                in_list = 0; exp_vld = 1;
            end
            if (out_valid && out_ready) exp_vld = 0;
            armed = 1;
        end
    end

    task automatic send_base(input logic [WIDTH-1:0] b, input logic eq);
        bit ok = 0;
        base_in = b; base_equal = eq; base_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (base_ready) begin ok = 1; break; end
            @(posedge clk); #1;
            idx_valid = 1'($urandom_range(0, 1));
            idx_in    = IDXW'($urandom);
            idx_last  = 1'($urandom_range(0, 1));
        end
        if (!ok) check("base_timeout", 0, 1);
        @(posedge clk); #1;
        base_valid = 1'b0; idx_valid = 1'b0;
    endtask

    task automatic send_idx(input int v, input logic last);
        bit ok = 0;
        idx_in = IDXW'(v); idx_last = last; idx_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (idx_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("idx_timeout", 0, 1);
        @(posedge clk); #1;
        idx_valid = 1'b0;
    endtask

    task automatic send_list(input logic [WIDTH-1:0] b, input logic eq, input int idx[$], input bit gaps);
        exp_q.push_back(model(b, eq, idx));
        send_base(b, eq);
        if (!eq) begin
            for (int i = 0; i < idx.size(); i++) begin
                if (gaps && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                end
                send_idx(idx[i], i == idx.size() - 1);
            end
        end
    endtask

    task automatic wait_out(input string name, input logic [WIDTH-1:0] w, input logic e,
                            input int nf, input logic er);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_word"}, out_word, w);
        check({name, "_equal"}, out_equal, e);
        check({name, "_nflips"}, out_nflips, nf);
        check({name, "_err"}, out_err, er);
        rdy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) break;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int q[$];
        res_t r;
        base_in = '0; base_equal = 0; base_valid = 0;
        idx_in = '0; idx_last = 0; idx_valid = 0; out_ready = 0;
        rdy_mode = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        q = '{3, 7, 31};
        r = model(32'h0, 1'b0, q);
        check("model_033", {r.word, 3'b0, r.equal, r.nflips, r.err}, {32'h8000_0088, 3'b0, 1'b0, 6'd3, 1'b0});
        send_list(32'h0, 1'b0, q, 1'b0);
        wait_out("req033", 32'h8000_0088, 1'b0, 3, 1'b0);

        rdy_mode = 0;
        q = {};
        send_list(32'hDEAD_BEEF, 1'b1, q, 1'b0);
        wait_out("req034", 32'hDEAD_BEEF, 1'b1, 0, 1'b0);

        rdy_mode = 0;
        q = '{4, 4};
        r = model(32'hFFFF_FFFF, 1'b0, q);
        check("model_035", {r.word, r.nflips, r.err}, {32'hFFFF_FFFF, 6'd2, 1'b1});
        send_list(32'hFFFF_FFFF, 1'b0, q, 1'b0);
        wait_out("req035", 32'hFFFF_FFFF, 1'b0, 2, 1'b1);

        rdy_mode = 0;
        q = '{0, 1, 2};
        send_list(32'h1234_5678, 1'b0, q, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            idx_valid = ~idx_valid; idx_in = IDXW'($urandom); idx_last = 1'b1;
        end
        idx_valid = 1'b0;
        wait_out("req036", 32'h1234_567F, 1'b0, 3, 1'b0);

        rdy_mode = 2;
        send_base(32'hA5A5_A5A5, 1'b0);
        send_idx(1, 1'b0);
        send_idx(2, 1'b0);
        rst = 1'b1;
        #1;
        check("req037_rst_valid", out_valid, 0);
        check("req037_rst_word", out_word, 0);
        check("req037_rst_ready", {base_ready, idx_ready}, 0);
        @(posedge clk); #1 rst = 1'b0;
        rdy_mode = 0;
        q = '{0};
        send_list(32'h1, 1'b0, q, 1'b0);
        wait_out("req037", 32'h0, 1'b0, 1, 1'b0);

        rdy_mode = 0;
        q = {};
        for (int i = 0; i < WIDTH; i++) q.push_back(i);
        q.push_back(0); q.push_back(1);
        send_list(32'h0, 1'b0, q, 1'b0);
        wait_out("sat", 32'hFFFF_FFFC, 1'b0, WIDTH, 1'b1);

        rdy_mode = 1;
        for (int l = 0; l < 60; l++) begin
            int n, p, v;
            logic eq;
            q = {};
            eq = ($urandom_range(0, 4) == 0);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(33, 36) : $urandom_range(1, 6);
            p = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) v = $urandom_range(0, WIDTH - 1);
                else begin v = p; p += $urandom_range(1, 4); end
                if (v >= WIDTH) v = $urandom_range(0, WIDTH - 1);
                q.push_back(v);
            end
            send_list($urandom, eq, q, ($urandom_range(0, 1) == 1));
        end

        rdy_mode = 2;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
